// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock.
// A START accepted in IDLE latches the operands. CALC then runs DATA_WIDTH
// shift-and-subtract iterations. FINISH registers the results and pulses DONE.
// A zero divisor bypasses CALC: the quotient is all ones and the remainder is the dividend.
// Optional build macro SIGNED_DIV_EN: two's-complement operands. The divider
// works on magnitudes and fixes the signs in FINISH (truncation toward zero).
module seq_restoring_divider #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  START,
   input  logic [DATA_WIDTH-1:0] DIVIDEND,
   input  logic [DATA_WIDTH-1:0] DIVISOR,
   output logic [DATA_WIDTH-1:0] QUOTIENT,
   output logic [DATA_WIDTH-1:0] REMAINDER,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  DIV_BY_ZERO
);

   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q;
   logic                  done_q;
   logic                  dbz_q;
   logic                  accept;
   logic                  zero_dvs;

   // Working registers. quo_q starts as the dividend and is shifted out
   // MSB-first into the partial remainder while quotient bits enter its LSB.
   logic [DATA_WIDTH-1:0] rem_q;
   logic [DATA_WIDTH-1:0] quo_q;
   logic [DATA_WIDTH-1:0] dvs_q;

   // One iteration of restoring division.
   logic        [DATA_WIDTH:0]   rem_shift;
   logic signed [DATA_WIDTH:0]   trial;
   logic        [DATA_WIDTH-1:0] rem_next;
   logic                         qbit;

   // Values presented to the output registers in FINISH.
   logic [DATA_WIDTH-1:0] final_quo;
   logic [DATA_WIDTH-1:0] final_rem;

   // The latched operands are unsigned magnitudes.
   logic [DATA_WIDTH-1:0] dvd_mag;
   logic [DATA_WIDTH-1:0] dvs_mag;

`ifdef SIGNED_DIV_EN
   logic sq_q;
   logic sr_q;

   // Two's-complement negation when en is set, pass-through otherwise.
   function automatic logic [DATA_WIDTH-1:0] neg_if(input logic [DATA_WIDTH-1:0] v,
                                                    input logic                  en);
      logic [DATA_WIDTH-1:0] r;
      r = en ? (~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1}) : v;
      return r;
   endfunction

   // Magnitude of a signed value. The most-negative value maps to itself,
   // which is still the correct magnitude when read as unsigned.
   function automatic logic [DATA_WIDTH-1:0] abs_val(input logic signed [DATA_WIDTH-1:0] v);
      return neg_if(v, v[DATA_WIDTH-1]);
   endfunction

   assign dvd_mag = abs_val($signed(DIVIDEND));
   assign dvs_mag = abs_val($signed(DIVISOR));

   // A divide-by-zero result is already in its final form, so it skips the sign fix-up.
   assign final_quo = dbz_q ? quo_q : neg_if(quo_q, sq_q);
   assign final_rem = dbz_q ? rem_q : neg_if(rem_q, sr_q);
`else
   assign dvd_mag   = DIVIDEND;
   assign dvs_mag   = DIVISOR;
   assign final_quo = quo_q;
   assign final_rem = rem_q;
`endif

   // Shift {rem, quo} left by one. The dividend MSB enters the remainder.
   assign rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
   // rem_q < divisor always holds, so bit DATA_WIDTH of the trial is its sign.
   assign trial     = $signed(rem_shift - {1'b0, dvs_q});
   assign qbit      = ~trial[DATA_WIDTH];
   assign rem_next  = qbit ? trial[DATA_WIDTH-1:0] : rem_shift[DATA_WIDTH-1:0];

   assign BUSY        = (state_q != IDLE);
   assign DONE        = done_q;
   assign DIV_BY_ZERO = dbz_q;

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and launch decode. A START during the DONE cycle is dropped.
   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      zero_dvs = (DIVISOR == '0);
      case (state_q)
         IDLE: begin
            if (START && !done_q) begin
               accept  = 1'b1;
               state_d = zero_dvs ? FINISH : CALC;
            end
         end
         CALC: begin
            if (cnt_q == CNT_ONE) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and output registers: iteration counter, DONE pulse, flag, results.
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q     <= '0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
         QUOTIENT  <= '0;
         REMAINDER <= '0;
      end else begin
         done_q <= (state_q == FINISH);
         if (accept) begin
            dbz_q <= zero_dvs;
            cnt_q <= zero_dvs ? '0 : CNT_LOAD;
         end else if (state_q == CALC) begin
            cnt_q <= cnt_q - CNT_ONE;
         end
         if (state_q == FINISH) begin
            QUOTIENT  <= final_quo;
            REMAINDER <= final_rem;
         end
      end
   end

   // Datapath working registers. They are loaded on launch, so they need no reset.
   always_ff @(posedge CLK) begin
      if (accept) begin
         if (zero_dvs) begin
            quo_q <= '1;
            rem_q <= DIVIDEND;
            dvs_q <= DIVISOR;
         end else begin
            quo_q <= dvd_mag;
            rem_q <= '0;
            dvs_q <= dvs_mag;
         end
      end else if (state_q == CALC) begin
         quo_q <= {quo_q[DATA_WIDTH-2:0], qbit};
         rem_q <= rem_next;
      end
   end

`ifdef SIGNED_DIV_EN
   // Result sign flags captured on launch.
   always_ff @(posedge CLK) begin
      if (accept) begin
         sq_q <= DIVIDEND[DATA_WIDTH-1] ^ DIVISOR[DATA_WIDTH-1];
         sr_q <= DIVIDEND[DATA_WIDTH-1];
      end
   end
`endif

endmodule
